// File: rtl/mem_arbiter.sv
// Two-requester (fetch IF / data D) arbiter in front of one single-port synchronous memory.
// Optional macro DATA_PRIO_EN: D always wins ties instead of round-robin.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    logic [0:0] r_state;
    logic [1:0] r_cnt;
    logic       r_pend;
    logic       r_owner;    // 1 = D owns the read in flight
`ifndef DATA_PRIO_EN
    logic       r_last_d;   // 1 = last grant went to D
`endif

    logic w_grantable;
    logic w_ret;
    logic w_pick_d;
    logic w_gnt;
    logic w_gnt_d;
    logic w_gnt_if;
    logic w_rd;

    // Outputs are gated by rst so nothing leaks out while reset is asserted.
    assign w_grantable = rst && (r_state == S_IDLE);
    assign w_ret       = rst && r_pend && (r_state == S_IDLE);

`ifdef DATA_PRIO_EN
    assign w_pick_d = d_req;
`else
    assign w_pick_d = d_req && (!if_req || !r_last_d);
`endif

    assign w_gnt    = w_grantable && (if_req || d_req);
    assign w_gnt_d  = w_gnt && w_pick_d;
    assign w_gnt_if = w_gnt && !w_pick_d;
    assign w_rd     = w_gnt_if || (w_gnt_d && !d_we);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_pend  <= 1'b0;
            r_owner <= 1'b0;
`ifndef DATA_PRIO_EN
            r_last_d <= 1'b1;
`endif
        end else begin
`ifndef DATA_PRIO_EN
            if (w_gnt) begin
                r_last_d <= w_gnt_d;
            end
`endif
            if (w_rd) begin
                r_pend  <= 1'b1;
                r_owner <= w_gnt_d;
                r_cnt   <= LAT_M1;
                r_state <= (MEM_LAT > 1) ? S_WAIT : S_IDLE;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    r_state <= S_IDLE;
                end
            end else if (w_ret) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign if_gnt    = w_gnt_if;
    assign d_gnt     = w_gnt_d;
    assign mem_en    = w_gnt;
    assign mem_we    = w_gnt_d && d_we;
    assign mem_addr  = w_gnt_d ? d_addr : (w_gnt_if ? if_addr : '0);
    assign mem_wdata = w_gnt_d ? d_wdata : '0;

    // Read data passes straight through to whoever owns the returning read.
    assign if_rvalid = w_ret && !r_owner;
    assign d_rvalid  = w_ret && r_owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT = 1, 3, 4) with a delayed-address memory model.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int EW = 69;

    logic clk;
    logic rst;
    int   cyc;

    logic [N-1:0] if_req, if_gnt, if_rvalid;
    logic [N-1:0] d_req, d_we, d_gnt, d_rvalid;
    logic [N-1:0] mem_en, mem_we;
    logic [15:0]  if_addr [N];
    logic [15:0]  d_addr [N];
    logic [15:0]  mem_addr [N];
    logic [31:0]  if_rdata [N];
    logic [31:0]  d_wdata [N];
    logic [31:0]  d_rdata [N];
    logic [31:0]  mem_wdata [N];
    logic [31:0]  mem_rdata [N];

    logic [EW-1:0] exp_g[$];
    logic [EW-1:0] exp_r[$];

    int total;
    int bad;
    int idle_cyc;
    int idle_k;
    bit done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [15:0] pipe [4];

        // Memory returns the zero-extended address presented LAT cycles earlier.
        always @(posedge clk) begin
            pipe[0] <= mem_addr[g];
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_rdata[g] = {16'h0000, pipe[LAT-1]};

        mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    function automatic logic [EW-1:0] mk_g(int c, int k, bit port, bit we,
                                           logic [15:0] a, logic [31:0] wd);
        logic [15:0] c16;
        logic [1:0]  k2;
        c16 = c[15:0];
        k2  = k[1:0];
        return {c16, k2, port, 1'b1, we, a, wd};
    endfunction

    function automatic logic [EW-1:0] mk_r(int c, int k, bit port, logic [31:0] data);
        logic [15:0] c16;
        logic [1:0]  k2;
        c16 = c[15:0];
        k2  = k[1:0];
        return {c16, k2, port, 18'h0, data};
    endfunction

    function automatic bit rr_port(int i);
`ifdef DATA_PRIO_EN
        return 1'b1;
`else
        return (i % 2) == 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected grants/returns whenever the DUT presents one.
    always @(negedge clk) begin
        logic [EW-1:0]  act;
        logic [EW-1:0]  e;
        logic [117:0]   outs;
        logic [15:0]    c16;
        logic [1:0]     k2;
        c16 = cyc[15:0];
        for (int k = 0; k < N; k++) begin
            k2 = k[1:0];
            outs = {if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
                    mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k]};
            if (!rst) begin
                total++;
                if (outs != '0) begin
                    bad++;
                    $display("FAIL reset_zero inst=%0d cyc=%0d got=%h want=0", k, cyc, outs);
                end
            end else begin
                if (if_gnt[k] || d_gnt[k]) begin
                    total++;
                    act = {c16, k2, d_gnt[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k]};
                    if (exp_g.size() == 0) begin
                        bad++;
                        $display("FAIL grant_unexpected inst=%0d cyc=%0d got=%h want=none", k, cyc, act);
                    end else begin
                        e = exp_g.pop_front();
                        if (act !== e || (if_gnt[k] && d_gnt[k])) begin
                            bad++;
                            $display("FAIL grant inst=%0d cyc=%0d got=%h want=%h both=%0b",
                                     k, cyc, act, e, if_gnt[k] && d_gnt[k]);
                        end
                    end
                end else if (mem_en[k]) begin
                    total++;
                    bad++;
                    $display("FAIL mem_en_no_grant inst=%0d cyc=%0d got=1 want=0", k, cyc);
                end
                if (if_rvalid[k] || d_rvalid[k]) begin
                    total++;
                    act = {c16, k2, d_rvalid[k], 18'h0, d_rvalid[k] ? d_rdata[k] : if_rdata[k]};
                    if (exp_r.size() == 0) begin
                        bad++;
                        $display("FAIL rvalid_unexpected inst=%0d cyc=%0d got=%h want=none", k, cyc, act);
                    end else begin
                        e = exp_r.pop_front();
                        if (act !== e || (if_rvalid[k] && d_rvalid[k])) begin
                            bad++;
                            $display("FAIL rvalid inst=%0d cyc=%0d got=%h want=%h both=%0b",
                                     k, cyc, act, e, if_rvalid[k] && d_rvalid[k]);
                        end
                    end
                end
                total++;
                if ((!if_rvalid[k] && if_rdata[k] != 0) || (!d_rvalid[k] && d_rdata[k] != 0)) begin
                    bad++;
                    $display("FAIL rdata_leak inst=%0d cyc=%0d got if=%h d=%h want=0",
                             k, cyc, if_rdata[k], d_rdata[k]);
                end
                if (cyc == idle_cyc && k == idle_k) begin
                    total++;
                    if (outs != '0) begin
                        bad++;
                        $display("FAIL idle_after_reset inst=%0d cyc=%0d got=%h want=0", k, cyc, outs);
                    end
                end
            end
        end
        if (done) begin
            total++;
            if (exp_g.size() != 0) begin
                bad++;
                $display("FAIL grants_missing got_left=%0d want=0", exp_g.size());
            end
            total++;
            if (exp_r.size() != 0) begin
                bad++;
                $display("FAIL rvalids_missing got_left=%0d want=0", exp_r.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        int t;
        total    = 0;
        bad      = 0;
        idle_cyc = -1;
        idle_k   = -1;
        done     = 1'b0;
        rst      = 1'b0;
        for (int k = 0; k < N; k++) begin
            if_req[k]  = 1'b0;
            d_req[k]   = 1'b0;
            d_we[k]    = 1'b0;
            if_addr[k] = 16'h0;
            d_addr[k]  = 16'h0;
            d_wdata[k] = 32'h0;
        end

        // Reset priority and back-to-back reads (MEM_LAT=1).
        if_req[0]  = 1'b1;
        d_req[0]   = 1'b1;
        if_addr[0] = 16'h0100;
        d_addr[0]  = 16'h0200;
        repeat (3) tick();
        rst = 1'b1;
        t = cyc;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            a = rr_port(i) ? 16'h0200 : 16'h0100;
            exp_g.push_back(mk_g(t + i, 0, rr_port(i), 1'b0, a, 32'h0));
            exp_r.push_back(mk_r(t + i + 1, 0, rr_port(i), {16'h0, a}));
        end
        repeat (8) tick();
        if_req[0] = 1'b0;
        d_req[0]  = 1'b0;
        repeat (2) tick();

        // Latency 3: D read, then IF waits until the return cycle.
        t = cyc;
        d_req[1]  = 1'b1;
        d_addr[1] = 16'h0010;
        exp_g.push_back(mk_g(t, 1, 1'b1, 1'b0, 16'h0010, 32'h0));
        exp_r.push_back(mk_r(t + 3, 1, 1'b1, 32'h0000_0010));
        tick();
        d_req[1]   = 1'b0;
        if_req[1]  = 1'b1;
        if_addr[1] = 16'h0030;
        exp_g.push_back(mk_g(t + 3, 1, 1'b0, 1'b0, 16'h0030, 32'h0));
        exp_r.push_back(mk_r(t + 6, 1, 1'b0, 32'h0000_0030));
        repeat (3) tick();
        if_req[1] = 1'b0;
        repeat (3) tick();

        // Fetch, then write beats pending fetch, pending fetch served next cycle.
        t = cyc;
        if_req[0]  = 1'b1;
        if_addr[0] = 16'h0040;
        exp_g.push_back(mk_g(t, 0, 1'b0, 1'b0, 16'h0040, 32'h0));
        exp_r.push_back(mk_r(t + 1, 0, 1'b0, 32'h0000_0040));
        tick();
        if_addr[0] = 16'h0044;
        d_req[0]   = 1'b1;
        d_we[0]    = 1'b1;
        d_addr[0]  = 16'h0020;
        d_wdata[0] = 32'hDEAD_BEEF;
        exp_g.push_back(mk_g(t + 1, 0, 1'b1, 1'b1, 16'h0020, 32'hDEAD_BEEF));
        exp_g.push_back(mk_g(t + 2, 0, 1'b0, 1'b0, 16'h0044, 32'h0));
        exp_r.push_back(mk_r(t + 3, 0, 1'b0, 32'h0000_0044));
        tick();
        d_req[0]   = 1'b0;
        d_we[0]    = 1'b0;
        d_wdata[0] = 32'h0;
        tick();
        if_req[0] = 1'b0;
        repeat (2) tick();

        // Latency 4: reset while the read is in flight drops its return.
        t = cyc;
        d_req[2]  = 1'b1;
        d_addr[2] = 16'h0050;
        exp_g.push_back(mk_g(t, 2, 1'b1, 1'b0, 16'h0050, 32'h0));
        tick();
        d_req[2] = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        rst      = 1'b1;
        idle_cyc = t + 4;
        idle_k   = 2;
        repeat (2) tick();
        if_req[2]  = 1'b1;
        if_addr[2] = 16'h0060;
        exp_g.push_back(mk_g(t + 6, 2, 1'b0, 1'b0, 16'h0060, 32'h0));
        exp_r.push_back(mk_r(t + 10, 2, 1'b0, 32'h0000_0060));
        tick();
        if_req[2] = 1'b0;
        repeat (4) tick();

        // Both held six cycles, then D drops and IF is served.
        t = cyc;
        if_req[0]  = 1'b1;
        if_addr[0] = 16'h0070;
        d_req[0]   = 1'b1;
        d_addr[0]  = 16'h0080;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            a = rr_port(i) ? 16'h0080 : 16'h0070;
            exp_g.push_back(mk_g(t + i, 0, rr_port(i), 1'b0, a, 32'h0));
            exp_r.push_back(mk_r(t + i + 1, 0, rr_port(i), {16'h0, a}));
        end
        exp_g.push_back(mk_g(t + 6, 0, 1'b0, 1'b0, 16'h0070, 32'h0));
        exp_r.push_back(mk_r(t + 7, 0, 1'b0, 32'h0000_0070));
        repeat (6) tick();
        d_req[0] = 1'b0;
        tick();
        if_req[0] = 1'b0;
        repeat (3) tick();

        done = 1'b1;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port synchronous memory between the CPU instruction-fetch port (IF) and the load/store data port (D).
- Sits between the fetch/datapath logic and a unified memory macro.
- One access outstanding at a time; round-robin grant; fixed-latency read return routed back to the owning requester.

Parameters:
AW, 16, address width (matches PC width)
DW, 32, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle grant pulse to IF
if_rvalid  out  1  fetch read data valid
if_rdata  out  DW  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_gnt  out  1  one-cycle grant pulse to D
d_rvalid  out  1  data read valid (reads only)
d_rdata  out  DW  data read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (rst=0 at rising edge): FSM to IDLE; wait counter = 0; pending-owner cleared; last_gnt = D, so IF wins the first tie. All outputs 0 while in reset and in the first cycle after release with no request.
- States:
  - IDLE: may grant.
  - WAIT: read in flight; no grant.
- Grant (combinational from registered state):
  - Occurs in any cycle where the state is IDLE, or the read in flight completes this cycle, and at least one req is high.
  - Grant cycle T: mem_en=1; mem_addr/mem_we/mem_wdata muxed from the winner; winner's gnt=1.
  - mem_we=0 and mem_wdata=0 for IF grants.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: winner = requester other than last_gnt.
  - last_gnt updates only on a grant.
- Write grant: no rvalid; state stays/returns IDLE; next grant is possible at T+1.
- Read grant at T:
  - Owner registered.
  - Counter loaded MEM_LAT-1. If MEM_LAT>1, go WAIT for cycles T+1..T+MEM_LAT-1.
  - At T+MEM_LAT: owner's rvalid=1 and owner's rdata = mem_rdata (combinational pass-through). A new grant is allowed in the same cycle.
  - MEM_LAT=1 therefore gives back-to-back reads, one per cycle.
- Non-owner rvalid is 0 and its rdata is held at 0.
- if_rdata and d_rdata are 0 whenever the corresponding rvalid is 0.
- A req dropped before gnt is legal and is simply not granted. Requesters must not change fields while req is held.
- Reset mid-read: the pending response is discarded; no rvalid after release.
- Simultaneous rvalid to one port and gnt to the other port in the same cycle is legal and expected.

Optional Feature:
- Macro DATA_PRIO_EN.
- Defined: fixed priority; D always wins ties; last_gnt is unused.
- Undefined: round-robin as above.
- All timing is identical in both modes.

Test Plan:
1. Reset priority: hold rst=0 3 cycles with both reqs high → all outputs 0. Release with if_req=d_req=1, reads, MEM_LAT=1 → if_gnt in first cycle, d_gnt next cycle.
2. Back-to-back reads, MEM_LAT=1, both reqs held 8 cycles, mem_rdata = address → grants alternate IF,D,IF,D. Each cycle rvalid goes to the previous cycle's winner with rdata = its address.
3. Latency, MEM_LAT=3: D read at 0x0010 granted at T, if_req raised at T+1 → mem_en only at T. d_rvalid at T+3 with mem_rdata. if_gnt at T+3, not before.
4. Write then fetch: d_we=1, d_addr=0x0020, d_wdata=0xDEADBEEF at T → mem_we=1 with those values, d_gnt=1, no d_rvalid. Pending if_req granted at T+1.
5. Reset during WAIT (MEM_LAT=4): assert rst=0 at T+2 after a read grant → no rvalid at T+4; outputs 0; next request after release is granted normally.
6. DATA_PRIO_EN defined: both reqs held 6 cycles → d_gnt every grant, if_gnt never. Drop d_req → if_gnt in the next grantable cycle.
